// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
// Optional wait states are enabled by defining MEM_RESPONDER_WAIT_EN.
`timescale 1ns/1ps
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WB_B0 = 4'b0001;
  localparam logic [3:0] WB_H0 = 4'b0011;
  localparam logic [3:0] WB_H1 = 4'b1100;
  localparam logic [3:0] WB_W  = 4'b1111;

  localparam int DEF_DEPTH_WORDS = 4096;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        bad;
    logic [3:0]  wrbits;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
// The read register clears on reset or on clr; the array itself is never cleared.
`timescale 1ns/1ps
module mem_responder_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          re,
  input  logic          clr,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE/WAIT/RESP handshake over a word RAM.
// Define MEM_RESPONDER_WAIT_EN to honour WAIT_CYCLES; otherwise WAIT is one cycle.
`timescale 1ns/1ps
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wrbits,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t        state, state_nx;
  req_t          req;
  logic [AW-1:0] widx;
  logic          accept;
  logic          wait_done;
  logic          commit;
  logic          addr_bad;
  logic          unused_ok;

  assign accept   = (state == IDLE) && (mem_read || mem_write);
  assign addr_bad = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
  assign commit   = (state == WAIT) && wait_done;
  assign unused_ok = &{1'b0, addr[1:0], WAIT_CYCLES[0]};

`ifdef MEM_RESPONDER_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              cnt <= '0;
    else if (accept)                        cnt <= LOAD;
    else if (state == WAIT && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign wait_done = (cnt == '0);
`else
  assign wait_done = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (wait_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == RESP);
      err   <= (state_nx == RESP) && req.bad;
    end
  end

  // Request capture has no reset: it is only consumed after a fresh accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      req.rd     <= mem_read;
      req.wr     <= mem_write;
      req.bad    <= (mem_read && mem_write) || addr_bad;
      req.wrbits <= mem_wrbits;
      req.wdata  <= wdata;
      widx       <= addr[AW+1:2];
    end
  end

  mem_responder_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .re    (commit && req.rd && !req.bad),
    .clr   (commit && req.bad),
    .we    ((commit && req.wr && !req.bad) ? req.wrbits : 4'b0000),
    .addr  (widx),
    .wdata (req.wdata),
    .rdata (rdata)
  );

endmodule
